// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the CPU read path.
// First-word-fall-through read, count-derived status, sticky overflow flag.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             enq_valid,
    output logic             enq_ready,
    output logic [WIDTH-1:0] deq_data,
    output logic             deq_valid,
    input  logic             deq_ready,
    input  logic             flush,
    output logic [AW:0]      count,
    output logic             overflow,
    input  logic             overflow_clr
);

    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, empty, do_enq, do_deq;

    // Status decode and pointer/count/overflow next-state
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
        do_enq     = enq_valid & ~full & ~flush;
        do_deq     = deq_ready & ~empty & ~flush;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_enq) wptr_d = wptr_q + AW'(1);
            if (do_deq) rptr_d = rptr_q + AW'(1);
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // A byte dropped in the same cycle as a clear must still be reported
        if (overflow_clr) overflow_d = 1'b0;
        if (enq_valid & full & ~flush) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage: synchronous write, asynchronous read, no reset
    always_ff @(posedge clk) begin
        if (do_enq) mem[wptr_q] <= enq_data;
    end

    assign deq_data  = mem[rptr_q];
    assign enq_ready = ~full;
    assign deq_valid = ~empty;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue scoreboard compared every cycle.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] enq_data;
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] deq_data;
    logic             deq_valid;
    logic             deq_ready;
    logic             flush;
    logic [3:0]       count;
    logic             overflow;
    logic             overflow_clr;

    logic [WIDTH-1:0] exp_q[$];
    logic             exp_ov;
    int               n_total;
    int               n_pass;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .enq_data     (enq_data),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .deq_data     (deq_data),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .flush        (flush),
        .count        (count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic check_outputs();
        check("deq_valid", 32'(deq_valid), 32'(exp_q.size() != 0));
        check("enq_ready", 32'(enq_ready), 32'(exp_q.size() != DEPTH));
        check("count",     32'(count),     32'(exp_q.size()));
        check("overflow",  32'(overflow),  32'(exp_ov));
        if (exp_q.size() != 0)
            check("deq_data", 32'(deq_data), 32'(exp_q[0]));
    endtask

    // Drive one cycle of stimulus, check current outputs, then advance the model
    task automatic cycle(input logic ev, input logic [7:0] d, input logic dr,
                         input logic fl, input logic oc);
        logic full_m, enq_m, deq_m, ovset_m;
        enq_valid    = ev;
        enq_data     = d;
        deq_ready    = dr;
        flush        = fl;
        overflow_clr = oc;
        check_outputs();
        full_m  = (exp_q.size() == DEPTH);
        enq_m   = ev && !full_m && !fl;
        deq_m   = dr && (exp_q.size() != 0) && !fl;
        ovset_m = ev && full_m && !fl;
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
        else begin
            if (deq_m) void'(exp_q.pop_front());
            if (enq_m) exp_q.push_back(d);
        end
        if (ovset_m) exp_ov = 1'b1;
        else if (oc) exp_ov = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset between edges, check outputs before the next edge, release later
    task automatic mid_cycle_reset();
        enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0; overflow_clr = 1'b0;
        rst = 1'b0;
        #2;
        exp_q.delete();
        exp_ov = 1'b0;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_total = 0; n_pass = 0; exp_ov = 1'b0;
        rst = 1'b0; enq_valid = 1'b0; enq_data = '0; deq_ready = 1'b0;
        flush = 1'b0; overflow_clr = 1'b0;

        // 1: reset state before any clock edge
        #3;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle();

        // 2: single byte, including empty + simultaneous deq_ready
        cycle(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        idle();
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // 3: fill, overflow, drain, sticky flag
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle();

        // 4: steady-state traffic at count=3 across pointer wrap
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();

        // 5: full with same-cycle dequeue; overflow set beats clear
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        idle();

        // 6a: flush while full with enq_valid must not flag overflow
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h88, 1'b0, 1'b1, 1'b0);
        idle();

        // 6b: flush at count=5 keeps a set overflow flag
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        idle();

        // 6c: reset during a burst, then first byte after release
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h70 + i), 1'(i % 2), 1'b0, 1'b0);
        mid_cycle_reset();
        idle();
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle();
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte buffer directly downstream of the UART receiver.
- Accepts bytes from the receiver's ready/valid output and holds up to DEPTH entries, so the consumer (CPU MMIO read path) can fall behind without dropping characters.
- First-word-fall-through read side; no combinational path from input to output.
- Also reports occupancy, plus a sticky flag for bytes lost while full.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
WIDTH, 8, data width in bits
AW, $clog2(DEPTH), pointer width (derived; not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
enq_data  input  WIDTH  byte from receiver
enq_valid  input  1  receiver has a byte
enq_ready  output  1  FIFO can accept; equals !full
deq_data  output  WIDTH  head entry; valid only while deq_valid=1
deq_valid  output  1  FIFO non-empty
deq_ready  input  1  consumer takes head this cycle
flush  input  1  synchronous clear of contents
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: an enq_valid was presented while full
overflow_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (rst=0, async):
  - read/write pointers, count and overflow go to 0.
  - deq_valid=0 and enq_ready=1 immediately, without waiting for a clock edge.
  - Storage array is not reset.
  - Release is synchronous to clk.
- Enqueue fires when enq_valid & enq_ready:
  - writes enq_data at wptr; wptr increments mod DEPTH (natural wrap at AW bits).
- Dequeue fires when deq_valid & deq_ready:
  - rptr increments mod DEPTH.
  - deq_data = mem[rptr] continuously (FWFT).
- Write-to-read latency:
  - A byte written into an empty FIFO at edge N appears with deq_valid=1 after edge N; earliest dequeue is cycle N+1.
  - No empty bypass.
- count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on simultaneous enqueue+dequeue or on neither.
- Status outputs:
  - full = (count==DEPTH), empty = (count==0); both derived from the count register.
  - enq_ready = !full. It does not depend on deq_ready: while full, a same-cycle dequeue does not allow an enqueue.
  - deq_valid = !empty.
- Full + dequeue: count goes DEPTH->DEPTH-1; enq_ready=1 on the next cycle.
- Empty + enq_valid: byte accepted; deq_valid stays 0 this cycle (no enqueue-and-dequeue of the same byte in one cycle).
- overflow:
  - Set on any cycle with enq_valid=1 & full=1.
  - Cleared by overflow_clr=1; set wins if both occur in the same cycle.
  - Not cleared by flush.
- flush=1:
  - pointers and count go to 0 at the next edge.
  - Overrides any same-cycle enqueue/dequeue; the offered byte is not stored and not counted as an overflow.
- Pointer wrap: after DEPTH enqueues and DEPTH dequeues, pointers return to 0; data order is preserved across the wrap.
- Must not corrupt state when deq_ready=1 with deq_valid=0, or enq_valid=1 with enq_ready=0.
- Storage: inferable as distributed RAM (synchronous write, asynchronous read).

Test Plan:
1. Reset then idle:
   - assert rst=0 mid-cycle -> deq_valid=0, enq_ready=1, count=0, overflow=0 before the next clk edge.
2. Single byte:
   - enqueue 0xA5 into an empty FIFO -> deq_valid=1 and deq_data=0xA5 one cycle later.
   - dequeue -> count back to 0, deq_valid=0.
3. Fill and overflow (DEPTH=8):
   - enqueue 0x00..0x07 with deq_ready=0 -> count=8, enq_ready=0.
   - present 0xFF -> overflow=1, count stays 8.
   - drain -> outputs 0x00..0x07 in order.
   - overflow stays 1 until overflow_clr pulse.
4. Simultaneous traffic:
   - count=3, enq and deq fire together for 20 cycles with incrementing data -> count constant at 3.
   - output sequence correct across pointer wrap.
5. Full with dequeue:
   - count=8, deq_ready=1 and enq_valid=1 same cycle -> only the dequeue fires, count=7.
   - enqueue accepted next cycle.
6. Flush and mid-operation reset:
   - count=5, flush with enq_valid=1 -> count=0, deq_valid=0, overflow unchanged.
   - separately, rst=0 during a burst -> all counters zero.
   - first byte after release read back correctly.
